mdu_iter: RTL

- Iterative multiply/divide unit directly downstream of the multicycle controller.
- Consumes the controller's MUL_C / DIV_C / S_mdu strobes plus the rs/rt operands.
- Produces the 64-bit result as hi/lo, which the HI/LO registers take when HI_w/LO_w are asserted.
- Radix-2 datapath, one bit per clock. The controller holds its state while busy is high and resumes on done.

---
 rtl/mdu_pkg.sv | 12 +
 rtl/mdu_sign_fix.sv | 30 +++
 rtl/mdu_iter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// Shared constants for the iterative multiply/divide unit.
package mdu_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam int unsigned MDU_ITER = 32;

  localparam logic [31:0] DIV0_Q = 32'hFFFF_FFFF;

endpackage

// File: rtl/mdu_sign_fix.sv
// Sign handling for mdu_iter: operand magnitudes on the way in,
// conditional negation of product / quotient / remainder on the way out.
module mdu_sign_fix #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               s_mdu_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [WIDTH-1:0]   a_mag_o,
  output logic [WIDTH-1:0]   b_mag_o,
  input  logic [2*WIDTH-1:0] prod_i,
  input  logic               neg_prod_i,
  output logic [2*WIDTH-1:0] prod_o,
  input  logic [WIDTH-1:0]   quo_i,
  input  logic               neg_quo_i,
  output logic [WIDTH-1:0]   quo_o,
  input  logic [WIDTH-1:0]   rem_i,
  input  logic               neg_rem_i,
  output logic [WIDTH-1:0]   rem_o
);

  always_comb begin
    a_mag_o = (s_mdu_i && a_i[WIDTH-1]) ? -a_i : a_i;
    b_mag_o = (s_mdu_i && b_i[WIDTH-1]) ? -b_i : b_i;
    prod_o  = neg_prod_i ? -prod_i : prod_i;
    quo_o   = neg_quo_i  ? -quo_i  : quo_i;
    rem_o   = neg_rem_i  ? -rem_i  : rem_i;
  end

endmodule

// File: rtl/mdu_iter.sv
// Radix-2 iterative multiply/divide unit: one bit per clock, results on hi/lo
// with a one-cycle done pulse. A shared accumulator serves both operations.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = MDU_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mul_c,
  input  logic             div_c,
  input  logic             s_mdu,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(ITER + 1);

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               op_div_q, op_div_d;
  logic               neg_q_q, neg_q_d;
  logic               neg_r_q, neg_r_d;
  logic               div0_q, div0_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   a_mag, b_mag, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [WIDTH:0]     psum, rsh;

  mdu_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .s_mdu_i    (s_mdu),
    .a_i        (a),
    .b_i        (b),
    .a_mag_o    (a_mag),
    .b_mag_o    (b_mag),
    .prod_i     (acc_q),
    .neg_prod_i (neg_q_q),
    .prod_o     (prod_fix),
    .quo_i      (acc_q[WIDTH-1:0]),
    .neg_quo_i  (neg_q_q),
    .quo_o      (quo_fix),
    .rem_i      (acc_q[2*WIDTH-1:WIDTH]),
    .neg_rem_i  (neg_r_q),
    .rem_o      (rem_fix)
  );

  // Multiply keeps {P, multiplier}; P gets one extra carry bit during the add.
  // Divide keeps {R, Q}; the shifted remainder needs one extra bit for the trial.
  always_comb begin
    psum     = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {psum, acc_q[WIDTH-1:1]};
    rsh      = acc_q[2*WIDTH-1:WIDTH-1];
    if (rsh >= {1'b0, opnd_q}) begin
      div_next = {rsh[WIDTH-1:0] - opnd_q, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_next = {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_div_d = op_div_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    div0_d   = div0_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (div_c || mul_c) begin
          state_d  = CALC;
          cnt_d    = '0;
          op_div_d = div_c;
          neg_q_d  = s_mdu && (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r_d  = s_mdu && a[WIDTH-1];
          div0_d   = div_c && (b == '0);
          opnd_d   = div_c ? b_mag : a_mag;
          acc_d    = {{WIDTH{1'b0}}, (div_c ? a_mag : b_mag)};
        end
      end
      CALC: begin
        cnt_d = cnt_q + 1'b1;
        acc_d = op_div_q ? div_next : mul_next;
        if (cnt_q == CW'(ITER - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (op_div_q) begin
          lo_d = div0_q ? DIV0_Q[WIDTH-1:0] : quo_fix;
          hi_d = rem_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_div_q <= op_div_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      div0_q   <= div0_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
